instr_fetch: RTL



---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 132 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The master side issues in-order word requests; responses come back in order.
interface instr_fetch_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC and issues credit-limited in-order imem requests.
// Buffers {pc, instr} pairs and presents one registered pair per cycle to decode.
module instr_fetch #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    instr_fetch_if.master     imem,
    output logic              instr_valid,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   instr_out
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW+1:0] CREDITS = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [AW:0]     outstanding;
    logic [AW:0]     buf_count;
    logic [AW:0]     discard_cnt;
    logic [AW:0]     redir_discard;
    logic [AW+1:0]   credit_used;

    logic [XLEN-1:0] pc_fifo   [DEPTH];
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [XLEN-1:0] buf_instr [DEPTH];
    logic [AW-1:0]   pf_wr, pf_rd, bf_wr, bf_rd;

    logic accept, push, pop;

    always_comb begin
        credit_used    = (AW+2)'(outstanding) + (AW+2)'(buf_count);
        imem.imem_req  = (state == FETCH) && !redirect_valid && (credit_used < CREDITS);
        imem.imem_addr = pc_q;
        accept         = imem.imem_req && imem.imem_ready;
        push           = imem.imem_rvalid && (state == FETCH);
        pop            = !halt && (buf_count != '0);
        // A response landing on the redirect edge is already accounted for, so it is not discarded later.
        redir_discard  = (state == DRAIN) ? discard_cnt : outstanding;
        if (imem.imem_rvalid && (redir_discard != '0))
            redir_discard = redir_discard - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            outstanding <= '0;
            buf_count   <= '0;
            discard_cnt <= '0;
            pf_wr       <= '0;
            pf_rd       <= '0;
            bf_wr       <= '0;
            bf_rd       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            instr_out   <= NOP_INSTR;
        end else begin
            if (redirect_valid) begin
                instr_valid <= 1'b0;
                instr_out   <= NOP_INSTR;
            end else if (!halt) begin
                if (buf_count != '0) begin
                    instr_valid <= 1'b1;
                    pc_out      <= buf_pc[bf_rd];
                    instr_out   <= buf_instr[bf_rd];
                end else begin
                    instr_valid <= 1'b0;
                    instr_out   <= NOP_INSTR;
                end
            end

            if (redirect_valid) begin
                pc_q        <= redirect_pc & ~XLEN'(3);
                outstanding <= '0;
                buf_count   <= '0;
                pf_wr       <= '0;
                pf_rd       <= '0;
                bf_wr       <= '0;
                bf_rd       <= '0;
                discard_cnt <= redir_discard;
                state       <= (redir_discard != '0) ? DRAIN : FETCH;
            end else begin
                case (state)
                    IDLE: state <= FETCH;
                    DRAIN: begin
                        if (imem.imem_rvalid) begin
                            discard_cnt <= discard_cnt - CNT_ONE;
                            if (discard_cnt == CNT_ONE)
                                state <= FETCH;
                        end
                    end
                    default: ;
                endcase

                if (accept) begin
                    pc_fifo[pf_wr] <= pc_q;
                    pf_wr          <= pf_wr + PTR_ONE;
                    pc_q           <= pc_q + XLEN'(4);
                end
                if (push) begin
                    buf_pc[bf_wr]    <= pc_fifo[pf_rd];
                    buf_instr[bf_wr] <= imem.imem_rdata;
                    bf_wr            <= bf_wr + PTR_ONE;
                    pf_rd            <= pf_rd + PTR_ONE;
                end
                if (pop)
                    bf_rd <= bf_rd + PTR_ONE;

                if (accept && !push)
                    outstanding <= outstanding + CNT_ONE;
                else if (!accept && push)
                    outstanding <= outstanding - CNT_ONE;

                if (push && !pop)
                    buf_count <= buf_count + CNT_ONE;
                else if (!push && pop)
                    buf_count <= buf_count - CNT_ONE;
            end
        end
    end
endmodule
